// File: rtl/link_monitor.sv
// link_monitor: per-requestor load-link / store-conditional reservations.
// Ports: clk, rst_ (sync, active-low); per-channel ll/sc/st valid+addr in;
//   sc_pass (combinational SC verdict), resv_valid/resv_addr (registered).
module link_monitor #(
   parameter int BITS      = 32,
   parameter int CHANNELS  = 2,
   parameter int GRAN_BITS = 0,
   parameter int TIMEOUT   = 0
) (
   input  logic                     clk,
   input  logic                     rst_,
   input  logic [CHANNELS-1:0]      ll_valid,
   input  logic [CHANNELS*BITS-1:0] ll_addr,
   input  logic [CHANNELS-1:0]      sc_valid,
   input  logic [CHANNELS*BITS-1:0] sc_addr,
   input  logic [CHANNELS-1:0]      st_valid,
   input  logic [CHANNELS*BITS-1:0] st_addr,
   output logic [CHANNELS-1:0]      sc_pass,
   output logic [CHANNELS-1:0]      resv_valid,
   output logic [CHANNELS*BITS-1:0] resv_addr
);

   localparam int AW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [CHANNELS-1:0] cand;
   logic [CHANNELS-1:0] blocked;
   logic [CHANNELS-1:0] hit;
   logic [CHANNELS-1:0] expire;

   function automatic logic match(
      input logic [BITS-1:0] a,
      input logic [BITS-1:0] b
   );
      return a[BITS-1:GRAN_BITS] == b[BITS-1:GRAN_BITS];
   endfunction

   // A channel is blocked when a lower-index candidate targets the same
   // granule. Granule equality is transitive, so the lowest candidate in
   // each granule is exactly the one that passes; this avoids a
   // combinational dependency of sc_pass on itself.
   always_comb begin
      cand    = '0;
      blocked = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         cand[i] = rst_ & sc_valid[i] & ~ll_valid[i] & resv_valid[i]
                 & match(resv_addr[i*BITS +: BITS],
                         sc_addr[i*BITS +: BITS]);
      end
      for (int i = 0; i < CHANNELS; i++) begin
         for (int j = 0; j < CHANNELS; j++) begin
            if (j < i && cand[j] &&
                match(sc_addr[j*BITS +: BITS], sc_addr[i*BITS +: BITS]))
               blocked[i] = 1'b1;
         end
      end
   end

   assign sc_pass = cand & ~blocked;

   // Snoop: any store or successful SC to the reserved granule kills it.
   always_comb begin
      hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         for (int j = 0; j < CHANNELS; j++) begin
            if (st_valid[j] &&
                match(st_addr[j*BITS +: BITS], resv_addr[i*BITS +: BITS]))
               hit[i] = 1'b1;
            if (sc_pass[j] &&
                match(sc_addr[j*BITS +: BITS], resv_addr[i*BITS +: BITS]))
               hit[i] = 1'b1;
         end
      end
   end

   generate
      if (TIMEOUT > 0) begin : g_age
         logic [AW-1:0] age [CHANNELS];

         always_comb begin
            expire = '0;
            for (int i = 0; i < CHANNELS; i++)
               expire[i] = resv_valid[i] && (age[i] == AW'(TIMEOUT - 1));
         end

         always_ff @(posedge clk) begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (!rst_) begin
                  age[i] <= '0;
               end else if (ll_valid[i]) begin
                  age[i] <= '0;
               end else if (resv_valid[i] && !sc_valid[i] && !hit[i] &&
                            !expire[i] && age[i] != AW'(TIMEOUT)) begin
                  age[i] <= age[i] + AW'(1);
               end
            end
         end
      end else begin : g_no_age
         assign expire = '0;
      end
   endgenerate

   // Priority: LL, own SC, snooped write, timeout. The address is kept
   // when a reservation dies so it stays observable for debug.
   always_ff @(posedge clk) begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (!rst_) begin
            resv_valid[i]            <= 1'b0;
            resv_addr[i*BITS +: BITS] <= '0;
         end else if (ll_valid[i]) begin
            resv_valid[i]            <= 1'b1;
            resv_addr[i*BITS +: BITS] <= ll_addr[i*BITS +: BITS];
         end else if (sc_valid[i] || hit[i] || expire[i]) begin
            resv_valid[i] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_link_monitor.sv
// Bench for link_monitor: directed scenarios plus randomized traffic
// against a deadline-based reservation model, on two configurations.
module tb_link_monitor;
   localparam int B = 32;
   localparam int C = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_;
   logic [C-1:0]   ll_valid, sc_valid, st_valid;
   logic [C*B-1:0] ll_addr, sc_addr, st_addr;
   logic [C-1:0]   pass_a, valid_a, pass_b, valid_b;
   logic [C*B-1:0] addr_a, addr_b;

   int tests = 0;
   int fails = 0;

   link_monitor #(.BITS(B), .CHANNELS(C), .GRAN_BITS(0), .TIMEOUT(0)) u_a (
      .clk(clk), .rst_(rst_),
      .ll_valid(ll_valid), .ll_addr(ll_addr),
      .sc_valid(sc_valid), .sc_addr(sc_addr),
      .st_valid(st_valid), .st_addr(st_addr),
      .sc_pass(pass_a), .resv_valid(valid_a), .resv_addr(addr_a)
   );

   link_monitor #(.BITS(B), .CHANNELS(C), .GRAN_BITS(1), .TIMEOUT(4)) u_b (
      .clk(clk), .rst_(rst_),
      .ll_valid(ll_valid), .ll_addr(ll_addr),
      .sc_valid(sc_valid), .sc_addr(sc_addr),
      .st_valid(st_valid), .st_addr(st_addr),
      .sc_pass(pass_b), .resv_valid(valid_b), .resv_addr(addr_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ll_valid = '0;
      sc_valid = '0;
      st_valid = '0;
   endtask

   task automatic do_ll(input int c, input logic [B-1:0] a);
      ll_valid[c] = 1'b1;
      ll_addr[c*B +: B] = a;
   endtask

   task automatic do_sc(input int c, input logic [B-1:0] a);
      sc_valid[c] = 1'b1;
      sc_addr[c*B +: B] = a;
   endtask

   task automatic do_st(input int c, input logic [B-1:0] a);
      st_valid[c] = 1'b1;
      st_addr[c*B +: B] = a;
   endtask

   function automatic logic [B-1:0] gr(input logic [B-1:0] a, input int g);
      return a >> g;
   endfunction

   task automatic test_reset();
      idle();
      do_ll(0, 32'h10);
      tick();
      idle();
      rst_ = 1'b0;
      do_sc(0, 32'h10);
      #1;
      tests++;
      if (pass_a !== 2'b00 || pass_b !== 2'b00) begin
         fails++;
         $display("FAIL rst_pass_forced got %b/%b want 00", pass_a, pass_b);
      end
      tick();
      rst_ = 1'b1;
      #1;
      tests++;
      if (valid_a !== 2'b00 || valid_b !== 2'b00) begin
         fails++;
         $display("FAIL rst_valid got %b/%b want 00", valid_a, valid_b);
      end
      tests++;
      if (addr_a !== '0 || addr_b !== '0) begin
         fails++;
         $display("FAIL rst_addr got %h/%h want 0", addr_a, addr_b);
      end
      tests++;
      if (pass_a[0] !== 1'b0) begin
         fails++;
         $display("FAIL rst_sc_after got %b want 0", pass_a[0]);
      end
      tick();
      idle();
   endtask

   task automatic test_basic();
      idle();
      do_ll(0, 32'h40);
      tick();
      idle();
      tests++;
      if (valid_a[0] !== 1'b1 || addr_a[B-1:0] !== 32'h40) begin
         fails++;
         $display("FAIL basic_ll got v=%b a=%h want 1/40",
                  valid_a[0], addr_a[B-1:0]);
      end
      do_sc(0, 32'h40);
      #1;
      tests++;
      if (pass_a[0] !== 1'b1) begin
         fails++;
         $display("FAIL basic_sc_pass got %b want 1", pass_a[0]);
      end
      tick();
      #1;
      tests++;
      if (valid_a[0] !== 1'b0) begin
         fails++;
         $display("FAIL basic_consumed got %b want 0", valid_a[0]);
      end
      tests++;
      if (pass_a[0] !== 1'b0) begin
         fails++;
         $display("FAIL basic_second_sc got %b want 0", pass_a[0]);
      end
      tick();
      idle();
   endtask

   task automatic test_snoop();
      // exact-address store kills the reservation
      idle();
      do_ll(0, 32'h80);
      tick();
      idle();
      do_st(1, 32'h80);
      tick();
      idle();
      do_sc(0, 32'h80);
      #1;
      tests++;
      if (pass_a[0] !== 1'b0 || pass_b[0] !== 1'b0) begin
         fails++;
         $display("FAIL snoop_exact got %b/%b want 0/0", pass_a[0], pass_b[0]);
      end
      tick();
      // same 2-word granule only for the GRAN_BITS=1 instance
      idle();
      do_ll(0, 32'h80);
      tick();
      idle();
      do_st(1, 32'h81);
      tick();
      idle();
      do_sc(0, 32'h80);
      #1;
      tests++;
      if (pass_b[0] !== 1'b0 || pass_a[0] !== 1'b1) begin
         fails++;
         $display("FAIL snoop_gran got b=%b a=%b want b=0 a=1",
                  pass_b[0], pass_a[0]);
      end
      tick();
      // neighbouring granule leaves the reservation alone
      idle();
      do_ll(0, 32'h80);
      tick();
      idle();
      do_st(1, 32'h82);
      tick();
      idle();
      do_sc(0, 32'h80);
      #1;
      tests++;
      if (pass_b[0] !== 1'b1 || pass_a[0] !== 1'b1) begin
         fails++;
         $display("FAIL snoop_other got b=%b a=%b want 1/1",
                  pass_b[0], pass_a[0]);
      end
      tick();
      idle();
   endtask

   task automatic test_collision();
      idle();
      do_ll(0, 32'h100);
      do_ll(1, 32'h100);
      tick();
      idle();
      do_sc(0, 32'h100);
      do_sc(1, 32'h100);
      #1;
      tests++;
      if (pass_a !== 2'b01 || pass_b !== 2'b01) begin
         fails++;
         $display("FAIL collide_pass got %b/%b want 01", pass_a, pass_b);
      end
      tick();
      idle();
      tests++;
      if (valid_a !== 2'b00 || valid_b !== 2'b00) begin
         fails++;
         $display("FAIL collide_valid got %b/%b want 00", valid_a, valid_b);
      end
   endtask

   task automatic test_ll_vs_store();
      idle();
      do_ll(0, 32'h20);
      do_st(1, 32'h20);
      tick();
      idle();
      tests++;
      if (valid_a[0] !== 1'b1) begin
         fails++;
         $display("FAIL ll_vs_st_valid got %b want 1", valid_a[0]);
      end
      do_sc(0, 32'h20);
      #1;
      tests++;
      if (pass_a[0] !== 1'b1) begin
         fails++;
         $display("FAIL ll_vs_st_sc got %b want 1", pass_a[0]);
      end
      tick();
      idle();
   endtask

   task automatic test_timeout();
      idle();
      do_ll(0, 32'h200);
      tick();
      idle();
      repeat (3) tick();
      tests++;
      if (valid_b[0] !== 1'b1) begin
         fails++;
         $display("FAIL tmo_valid_last got %b want 1", valid_b[0]);
      end
      do_sc(0, 32'h200);
      #1;
      tests++;
      if (pass_b[0] !== 1'b1) begin
         fails++;
         $display("FAIL tmo_sc_last got %b want 1", pass_b[0]);
      end
      tick();
      idle();
      do_ll(0, 32'h200);
      tick();
      idle();
      repeat (4) tick();
      tests++;
      if (valid_b[0] !== 1'b0 || valid_a[0] !== 1'b1) begin
         fails++;
         $display("FAIL tmo_expired got b=%b a=%b want b=0 a=1",
                  valid_b[0], valid_a[0]);
      end
      do_sc(0, 32'h200);
      #1;
      tests++;
      if (pass_b[0] !== 1'b0) begin
         fails++;
         $display("FAIL tmo_sc_late got %b want 0", pass_b[0]);
      end
      tick();
      idle();
   endtask

   task automatic test_random();
      bit             mv [2][C];
      logic [B-1:0]   ma [2][C];
      int             dl [2][C];
      int             g  [2];
      int             to [2];
      logic [B-1:0]   pool [5];
      logic [C-1:0]   ep [2];
      logic [C-1:0]   ev;
      logic [C*B-1:0] ea;
      logic [B-1:0]   taken [$];
      int             cyc;
      bit             dup, kill;
      g[0] = 0;  g[1] = 1;
      to[0] = 0; to[1] = 4;
      pool[0] = 32'h40; pool[1] = 32'h41; pool[2] = 32'h42;
      pool[3] = 32'h43; pool[4] = 32'h80;
      idle();
      rst_ = 1'b0;
      tick();
      rst_ = 1'b1;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < C; i++) begin
            mv[d][i] = 1'b0;
            ma[d][i] = '0;
            dl[d][i] = 0;
         end
      cyc = 0;
      for (int n = 0; n < 400; n++) begin
         idle();
         for (int c = 0; c < C; c++) begin
            ll_valid[c] = ($urandom_range(0, 3) == 0);
            ll_addr[c*B +: B] = pool[$urandom_range(0, 4)];
            sc_valid[c] = ($urandom_range(0, 2) == 0);
            sc_addr[c*B +: B] = pool[$urandom_range(0, 4)];
            st_valid[c] = ($urandom_range(0, 4) == 0);
            st_addr[c*B +: B] = pool[$urandom_range(0, 4)];
         end
         rst_ = ($urandom_range(0, 29) != 0);
         #1;
         for (int d = 0; d < 2; d++) begin
            taken.delete();
            ep[d] = '0;
            for (int i = 0; i < C; i++) begin
               if (rst_ && sc_valid[i] && !ll_valid[i] && mv[d][i] &&
                   gr(sc_addr[i*B +: B], g[d]) == gr(ma[d][i], g[d])) begin
                  dup = 1'b0;
                  foreach (taken[k])
                     if (taken[k] == gr(sc_addr[i*B +: B], g[d])) dup = 1'b1;
                  if (!dup) begin
                     ep[d][i] = 1'b1;
                     taken.push_back(gr(sc_addr[i*B +: B], g[d]));
                  end
               end
            end
         end
         tests++;
         if (pass_a !== ep[0]) begin
            fails++;
            $display("FAIL rnd_pass_a n=%0d got %b want %b", n, pass_a, ep[0]);
         end
         tests++;
         if (pass_b !== ep[1]) begin
            fails++;
            $display("FAIL rnd_pass_b n=%0d got %b want %b", n, pass_b, ep[1]);
         end
         for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < C; i++) begin
               if (!rst_) begin
                  mv[d][i] = 1'b0;
                  ma[d][i] = '0;
               end else if (ll_valid[i]) begin
                  mv[d][i] = 1'b1;
                  ma[d][i] = ll_addr[i*B +: B];
                  dl[d][i] = cyc + to[d];
               end else begin
                  kill = sc_valid[i];
                  for (int j = 0; j < C; j++) begin
                     if (st_valid[j] &&
                         gr(st_addr[j*B +: B], g[d]) == gr(ma[d][i], g[d]))
                        kill = 1'b1;
                     if (ep[d][j] &&
                         gr(sc_addr[j*B +: B], g[d]) == gr(ma[d][i], g[d]))
                        kill = 1'b1;
                  end
                  if (to[d] > 0 && cyc >= dl[d][i]) kill = 1'b1;
                  if (kill) mv[d][i] = 1'b0;
               end
            end
         end
         cyc++;
         tick();
         for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < C; i++) begin
               ev[i] = mv[d][i];
               ea[i*B +: B] = ma[d][i];
            end
            tests++;
            if (d == 0 && (valid_a !== ev || addr_a !== ea)) begin
               fails++;
               $display("FAIL rnd_state_a n=%0d got %b %h want %b %h",
                        n, valid_a, addr_a, ev, ea);
            end
            if (d == 1 && (valid_b !== ev || addr_b !== ea)) begin
               fails++;
               $display("FAIL rnd_state_b n=%0d got %b %h want %b %h",
                        n, valid_b, addr_b, ev, ea);
            end
         end
      end
      rst_ = 1'b1;
      idle();
   endtask

   initial begin
      rst_ = 1'b0;
      ll_valid = '0; sc_valid = '0; st_valid = '0;
      ll_addr = '0; sc_addr = '0; st_addr = '0;
      tick();
      tick();
      rst_ = 1'b1;
      test_reset();
      test_basic();
      test_snoop();
      test_collision();
      test_ll_vs_store();
      test_timeout();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/link_monitor.md
# link_monitor

Parametrised load-link / store-conditional reservation monitor for multi-requestor data-memory ports. It generalises the single-entry link register of the pipelined core to CHANNELS independent reservations. It adds configurable match granularity, cross-channel snooping of stores and an optional reservation timeout. It sits beside the data memory; each requestor's execute stage presents LL/SC/store events, and the block returns a same-cycle SC pass/fail used to gate the memory write and the SC result written back to the register file.

## Interface
Parameters:
- BITS, 32, address width.
- CHANNELS, 2, number of requestors/reservations (≥1).
- GRAN_BITS, 0, low address bits ignored for matching (reservation granule = 2^GRAN_BITS words).
- TIMEOUT, 0, reservation lifetime in cycles; 0 disables expiry.

Ports (per-channel buses flattened, channel i at bits [i*BITS +: BITS] or [i]):
- clk  input  1  system clock.
- rst_  input  1  reset; synchronous, active-low.
- ll_valid  input  CHANNELS  load-link issued this cycle.
- ll_addr  input  CHANNELS*BITS  load-link address.
- sc_valid  input  CHANNELS  store-conditional issued this cycle.
- sc_addr  input  CHANNELS*BITS  store-conditional address.
- st_valid  input  CHANNELS  ordinary store issued this cycle.
- st_addr  input  CHANNELS*BITS  ordinary store address.
- sc_pass  output  CHANNELS  combinational; 1 = SC succeeds, the requestor performs the write and returns 1.
- resv_valid  output  CHANNELS  registered reservation-valid flags.
- resv_addr  output  CHANNELS*BITS  registered reservation addresses.

## Operation
- Per-channel state: resv_valid[i], resv_addr[i], age[i] (width $clog2(TIMEOUT+1), absent when TIMEOUT=0).
- Match(a,b): a[BITS-1:GRAN_BITS] == b[BITS-1:GRAN_BITS].
- sc_pass[i] = sc_valid[i] & ~ll_valid[i] & resv_valid[i] & match(resv_addr[i], sc_addr[i]) & no lower-index j with sc_pass[j] and match(sc_addr[j], sc_addr[i]).
- Same-granule SC collisions: the lowest index wins; all others fail.
- A "write event" from channel j is st_valid[j], or sc_pass[j].
- Per-channel next state, highest priority first:
  1. ll_valid[i]: resv_addr ← ll_addr[i]; resv_valid ← 1; age ← 0. LL beats any same-cycle write event and the channel's own SC. sc_valid with ll_valid on the same channel is illegal, and sc_pass is forced to 0.
  2. sc_valid[i]: resv_valid ← 0, pass or fail.
  3. Any write event from any channel j, including j=i, matching resv_addr[i]: resv_valid ← 0.
  4. TIMEOUT>0, resv_valid=1 and age=TIMEOUT-1: resv_valid ← 0.
  5. Else, if resv_valid: age ← age+1, saturating.
- resv_addr holds its value when a reservation is cleared.
- A failed SC and an unmatched store do not affect other channels.

## Timing
- Reset (rst_=0 at posedge): resv_valid=0, resv_addr=0, age=0. sc_pass is 0 while reset is asserted, and is forced low in the same cycle.
- LL in cycle t → resv_valid=1 from cycle t+1. An SC is first eligible in cycle t+1.
- sc_pass has zero latency: it is combinational from the registered state and the current-cycle inputs. The reservation is consumed at the edge ending the SC cycle.
- Clearing by a store in cycle t → resv_valid=0 from t+1. An SC in the same cycle t still sees the old valid flag; priority 2 applies to that channel.
- Timeout: LL in t → reservation valid for cycles t+1 … t+TIMEOUT. An SC in cycle t+TIMEOUT passes. resv_valid=0 from t+TIMEOUT+1.
- A re-LL while already valid restarts age at 0 and replaces the address.
- Reset asserted mid-reservation clears every channel at that edge. There is no drain.

## Test plan
- Basic LL/SC: ch0 LL 0x40 at t, SC 0x40 at t+1 → sc_pass[0]=1, resv_valid[0]=0 at t+2. A second SC 0x40 at t+2 → sc_pass[0]=0.
- Snoop: ch0 LL 0x80, then ch1 st 0x80 (GRAN_BITS=0) → ch0 SC 0x80 fails. Repeat with ch1 st 0x81 at GRAN_BITS=1 → fails. Repeat with ch1 st 0x82 at GRAN_BITS=1 → passes.
- Collision: ch0 and ch1 both LL 0x100, then both SC 0x100 in the same cycle → sc_pass=2'b01. Both resv_valid are 0 next cycle.
- LL vs store same cycle: ch0 LL 0x20 while ch1 st 0x20 → resv_valid[0]=1 next cycle. A subsequent ch0 SC 0x20 passes.
- Timeout (TIMEOUT=4): LL at t. SC at t+4 → pass. Separately, SC at t+5 → fail, with resv_valid=0 at t+5.
- Reset: ch0 LL 0x10, assert rst_=0 for one edge, then ch0 SC 0x10 → fail. All resv_valid and resv_addr are 0 after the reset edge.
